// File: rtl/timing_check_monitor.sv
// Setup/hold/min-width checker for NCH data channels against one monitored clock,
// all sampled on clk, with per-channel saturating violation counters for readout.
module timing_check_monitor #(
   parameter int NCH       = 4,
   parameter int AGE_W     = 8,
   parameter int SETUP     = 3,
   parameter int HOLD      = 2,
   parameter int MIN_WIDTH = 4,
   parameter int EDGE      = 0,
   parameter int VCNT_W    = 8,
   parameter int SEL_W     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              check_en,
   input  logic              mon_clk,
   input  logic [NCH-1:0]    mon_data,
   output logic [NCH-1:0]    setup_viol,
   output logic [NCH-1:0]    hold_viol,
   output logic              width_viol,
   output logic              notifier,
   input  logic [SEL_W-1:0]  cnt_sel,
   input  logic              cnt_clr,
   output logic [VCNT_W-1:0] cnt_rdata
);

   typedef logic [AGE_W-1:0]  age_t;
   typedef logic [VCNT_W-1:0] cnt_t;

   localparam age_t AGE_MAX = '1;
   localparam cnt_t CNT_MAX = '1;

   // Age is zero on the event tick, otherwise counts up and sticks at AGE_MAX.
   function automatic age_t age_step(input logic hit, input age_t age);
      if (hit) return '0;
      if (age == AGE_MAX) return AGE_MAX;
      return age + age_t'(1);
   endfunction

   logic           primed;
   logic           clk_s, clk_p, en_s;
   logic [NCH-1:0] data_s, data_p;
   age_t           data_age [NCH];
   age_t           edge_age, level_age;
   cnt_t           cnt [NCH];

   logic           act, tog, width_d;
   logic [NCH-1:0] chg, setup_d, hold_d, inc, clr_hit;
   age_t           data_age_now [NCH];
   age_t           edge_age_now, level_age_now, level_elapsed;

   // NOTE: every always_comb target gets a default first so no latch can be inferred.
   always_comb begin
      setup_d = '0;
      hold_d  = '0;
      tog     = primed & (clk_s ^ clk_p);
      chg     = primed ? (data_s ^ data_p) : '0;
      if (EDGE == 0)      act = primed & clk_s & ~clk_p;
      else if (EDGE == 1) act = primed & ~clk_s & clk_p;
      else                act = tog;

      edge_age_now  = age_step(act, edge_age);
      level_age_now = age_step(tog, level_age);
      // Width is judged on the elapsed level time, i.e. the age before it restarts.
      level_elapsed = age_step(1'b0, level_age);
      width_d = en_s && (MIN_WIDTH > 0) && tog && (int'(level_elapsed) < MIN_WIDTH);

      for (int i = 0; i < NCH; i++) begin
         data_age_now[i] = age_step(chg[i], data_age[i]);
         setup_d[i] = en_s && (SETUP > 0) && act && (int'(data_age_now[i]) < SETUP);
         hold_d[i]  = en_s && (HOLD > 0) && chg[i] && (edge_age_now != '0)
                      && (int'(edge_age_now) <= HOLD);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         primed     <= 1'b0;
         clk_s      <= 1'b0;
         clk_p      <= 1'b0;
         en_s       <= 1'b0;
         data_s     <= '0;
         data_p     <= '0;
         edge_age   <= AGE_MAX;
         level_age  <= AGE_MAX;
         setup_viol <= '0;
         hold_viol  <= '0;
         width_viol <= 1'b0;
         notifier   <= 1'b0;
         for (int i = 0; i < NCH; i++) data_age[i] <= AGE_MAX;
      end else begin
         primed <= 1'b1;
         clk_s  <= mon_clk;
         data_s <= mon_data;
         en_s   <= check_en;
         // The priming edge loads both stages so a high mon_clk is not seen as an edge.
         clk_p  <= primed ? clk_s : mon_clk;
         data_p <= primed ? data_s : mon_data;

         edge_age  <= edge_age_now;
         level_age <= level_age_now;
         for (int i = 0; i < NCH; i++) data_age[i] <= data_age_now[i];

         setup_viol <= setup_d;
         hold_viol  <= hold_d;
         width_viol <= width_d;
         if ((|setup_viol) || (|hold_viol) || width_viol) notifier <= ~notifier;
      end
   end

   always_comb begin
      inc       = setup_viol | hold_viol;
      clr_hit   = '0;
      cnt_rdata = '0;
      // Selects with no matching channel read 0 and clear nothing.
      for (int i = 0; i < NCH; i++) begin
         if (cnt_sel == SEL_W'(i)) begin
            clr_hit[i] = cnt_clr;
            cnt_rdata  = cnt[i];
         end
      end
   end

   // NOTE: the counter array is reset explicitly because readout must return 0 after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (clr_hit[i])                       cnt[i] <= inc[i] ? cnt_t'(1) : '0;
            else if (inc[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + cnt_t'(1);
         end
      end
   end

endmodule

// File: tb/tb_timing_check_monitor.sv
// Directed bench for timing_check_monitor: a per-tick vector table for setup, hold,
// width and check_en behaviour, then hand sequences for reset, saturation and clear.
module tb_timing_check_monitor;

   localparam int NCH    = 4;
   localparam int VCNT_W = 8;
   localparam int SEL_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              check_en;
   logic              mon_clk;
   logic [NCH-1:0]    mon_data;
   logic [NCH-1:0]    setup_viol;
   logic [NCH-1:0]    hold_viol;
   logic              width_viol;
   logic              notifier;
   logic [SEL_W-1:0]  cnt_sel;
   logic              cnt_clr;
   logic [VCNT_W-1:0] cnt_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   timing_check_monitor #(
      .NCH(NCH), .AGE_W(8), .SETUP(3), .HOLD(2), .MIN_WIDTH(4),
      .EDGE(0), .VCNT_W(VCNT_W), .SEL_W(SEL_W)
   ) dut (
      .clk(clk), .rst(rst), .check_en(check_en), .mon_clk(mon_clk),
      .mon_data(mon_data), .setup_viol(setup_viol), .hold_viol(hold_viol),
      .width_viol(width_viol), .notifier(notifier), .cnt_sel(cnt_sel),
      .cnt_clr(cnt_clr), .cnt_rdata(cnt_rdata)
   );

   // One row per clk tick: inputs applied that tick, outputs expected right after its edge.
   typedef struct {
      logic       c;
      logic [3:0] d;
      logic       en;
      logic [3:0] es;
      logic [3:0] eh;
      logic       ew;
      logic       n;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int reps, input logic c, input logic [3:0] d, input logic en,
                      input logic [3:0] es, input logic [3:0] eh, input logic ew,
                      input logic n);
      vec_t v;
      v.c = c; v.d = d; v.en = en; v.es = es; v.eh = eh; v.ew = ew; v.n = n;
      for (int k = 0; k < reps; k++) vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input int ch, input logic [7:0] exp, input string name);
      cnt_sel = SEL_W'(ch);
      #1;
      check(name, 32'(cnt_rdata), 32'(exp));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   pulses, stray;
      logic found;

      rst = 1'b0; check_en = 1'b1; mon_clk = 1'b0; mon_data = '0;
      cnt_sel = '0; cnt_clr = 1'b0;
      repeat (2) step();
      check("reset flags", 32'({setup_viol, hold_viol, width_viol}), 32'd0);
      check("reset notifier", 32'(notifier), 32'd0);
      check_cnt(0, 8'd0, "reset cnt0");
      rst = 1'b1;

      //  reps clk data     en setup    hold     w  notifier
      add(1,  0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0);  // priming tick
      add(2,  0, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0);  // ch0 toggles 2 ticks before rise
      add(1,  1, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0);
      add(1,  1, 4'b0001, 1, 4'b0001, 4'b0000, 0, 0);
      add(2,  1, 4'b0001, 1, 4'b0000, 4'b0000, 0, 1);
      add(4,  0, 4'b0001, 1, 4'b0000, 4'b0000, 0, 1);  // low 4 ticks: no width flag
      add(2,  1, 4'b0001, 1, 4'b0000, 4'b0000, 0, 1);
      add(1,  1, 4'b0101, 1, 4'b0000, 4'b0000, 0, 1);  // ch2 toggles 2 ticks after rise
      add(1,  1, 4'b0101, 1, 4'b0000, 4'b0100, 0, 1);
      add(4,  0, 4'b0101, 1, 4'b0000, 4'b0000, 0, 0);
      add(3,  1, 4'b0101, 1, 4'b0000, 4'b0000, 0, 0);
      add(1,  1, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0);  // ch2 toggles 3 ticks after rise
      add(4,  0, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0);
      add(1,  1, 4'b0011, 1, 4'b0000, 4'b0000, 0, 0);  // ch1 toggles with the rise
      add(1,  1, 4'b0011, 1, 4'b0010, 4'b0000, 0, 0);
      add(1,  1, 4'b0011, 1, 4'b0000, 4'b0000, 0, 1);  // high only 3 ticks
      add(1,  0, 4'b0011, 1, 4'b0000, 4'b0000, 0, 1);
      add(1,  0, 4'b0011, 1, 4'b0000, 4'b0000, 1, 1);
      add(2,  0, 4'b0011, 1, 4'b0000, 4'b0000, 0, 0);
      add(4,  1, 4'b0011, 1, 4'b0000, 4'b0000, 0, 0);  // high 4 ticks: no width flag
      add(2,  0, 4'b0011, 0, 4'b0000, 4'b0000, 0, 0);  // checking disabled
      add(2,  0, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0);
      add(3,  1, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0);  // suppressed setup violation
      add(1,  1, 4'b0010, 1, 4'b0000, 4'b0000, 0, 0);
      add(2,  0, 4'b0010, 1, 4'b0000, 4'b0000, 0, 0);
      add(2,  0, 4'b0011, 1, 4'b0000, 4'b0000, 0, 0);
      add(1,  1, 4'b0011, 1, 4'b0000, 4'b0000, 0, 0);
      add(1,  1, 4'b0011, 1, 4'b0001, 4'b0000, 0, 0);  // re-enabled violation flagged
      add(2,  1, 4'b0011, 1, 4'b0000, 4'b0000, 0, 1);

      for (int j = 0; j < vecs.size(); j++) begin
         mon_clk  = vecs[j].c;
         mon_data = vecs[j].d;
         check_en = vecs[j].en;
         step();
         check($sformatf("vec%0d setup", j), 32'(setup_viol), 32'(vecs[j].es));
         check($sformatf("vec%0d hold", j), 32'(hold_viol), 32'(vecs[j].eh));
         check($sformatf("vec%0d width", j), 32'(width_viol), 32'(vecs[j].ew));
         check($sformatf("vec%0d notifier", j), 32'(notifier), 32'(vecs[j].n));
      end

      check_cnt(0, 8'd2, "table cnt0");
      check_cnt(1, 8'd1, "table cnt1");
      check_cnt(2, 8'd1, "table cnt2");
      check_cnt(3, 8'd0, "table cnt3");

      // Mid-operation reset with mon_clk held high: no false edge after re-priming.
      rst = 1'b0;
      #1;
      check("midreset notifier", 32'(notifier), 32'd0);
      check_cnt(0, 8'd0, "midreset cnt0");
      mon_clk = 1'b1; mon_data = 4'b1010;
      repeat (2) step();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("reprime high %0d", k),
               32'({setup_viol, hold_viol, width_viol}), 32'd0);
      end
      mon_clk = 1'b0;  // first toggle after reset, only 3 ticks high
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("reprime low %0d", k),
               32'({setup_viol, hold_viol, width_viol}), 32'd0);
      end

      // 300 setup violations on ch3 saturate its counter.
      pulses = 0;
      stray  = 0;
      for (int p = 0; p < 300; p++) begin
         for (int t = 0; t < 8; t++) begin
            mon_clk = (t >= 4);
            if (t == 3) mon_data[3] = ~mon_data[3];
            step();
            if (setup_viol[3]) pulses++;
            if (setup_viol[2:0] != '0 || hold_viol != '0 || width_viol) stray++;
         end
      end
      check("sat pulses", 32'(pulses), 32'd300);
      check("sat stray flags", 32'(stray), 32'd0);
      check("sat notifier", 32'(notifier), 32'd0);
      check_cnt(3, 8'd255, "sat cnt3");
      check_cnt(0, 8'd0, "sat cnt0");

      // Clear coinciding with an increment on the same channel leaves 1.
      for (int t = 0; t < 5; t++) begin
         mon_clk = (t >= 4);
         if (t == 3) mon_data[3] = ~mon_data[3];
         step();
      end
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
         step();
         if (setup_viol[3]) found = 1'b1;
      end
      check("clr flag seen", 32'(found), 32'd1);
      cnt_sel = 2'd3;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check_cnt(3, 8'd1, "clr coincident cnt3");
      check("clr notifier", 32'(notifier), 32'd1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check_cnt(3, 8'd0, "clr plain cnt3");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
